// File: rtl/user_proj_mc_pkg.sv
// Shared definitions for the multi-channel counter user project:
// register map, CTRL/STATUS bit positions, freeze control bit and the
// byte-lane write merge used by every writable register.
package user_proj_mc_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_VALUE  = 2'd1,
    REG_LIMIT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_EVT     = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned CTRL_IRQ_EN  = 3;

  localparam int unsigned STAT_PENDING = 0;
  localparam int unsigned STAT_RUNNING = 1;

  localparam int unsigned FREEZE_LA_BIT = 127;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mc_channel.sv
// One counter channel: event-pin synchroniser and edge detect, the
// CTRL/VALUE/LIMIT/pending registers and the terminal-count behaviour.
module mc_channel
  import user_proj_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_pin,
  input  logic             freeze,
  input  logic             wr_en,
  input  reg_sel_e         wr_reg,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_sel,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] limit,
  output logic [3:0]       ctrl,
  output logic             pending
);

  logic        sync_1, sync_2, sync_2_d;
  logic        evt_rise, inc, term;
  logic        wr_ctrl, wr_value, wr_limit, wr_status, clr_pending;
  logic [31:0] merge_old, merged;

  assign wr_ctrl     = wr_en && (wr_reg == REG_CTRL);
  assign wr_value    = wr_en && (wr_reg == REG_VALUE);
  assign wr_limit    = wr_en && (wr_reg == REG_LIMIT);
  assign wr_status   = wr_en && (wr_reg == REG_STATUS);
  assign clr_pending = wr_status && wr_sel[0] && wr_data[STAT_PENDING];

  assign evt_rise = sync_2 & ~sync_2_d;

  // Step qualification: a bus write to CTRL or VALUE pre-empts the step.
  always_comb begin
    inc  = ctrl[CTRL_EN] & (ctrl[CTRL_EVT] ? evt_rise : 1'b1) & ~freeze
           & ~wr_ctrl & ~wr_value;
    term = inc && (value == limit);
  end

  // Merge the bus write into the addressed register, zero-extended to 32 bits.
  always_comb begin
    merge_old = '0;
    case (wr_reg)
      REG_CTRL:  merge_old[3:0]       = ctrl;
      REG_VALUE: merge_old[WIDTH-1:0] = value;
      REG_LIMIT: merge_old[WIDTH-1:0] = limit;
      default:   merge_old            = '0;
    endcase
    merged = byte_merge(merge_old, wr_data, wr_sel);
  end

  if (WIDTH < 32) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^merged[31:WIDTH];
  end

  // Two-flop synchroniser plus edge-detect flop on the event pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_d <= 1'b0;
    end else begin
      sync_1   <= evt_pin;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
    end
  end

  // Counter registers: bus writes take priority, then terminal count, then step.
  always_ff @(posedge clk) begin
    if (rst) begin
      value   <= '0;
      limit   <= '1;
      ctrl    <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= merged[3:0];
      else if (term && ctrl[CTRL_ONESHOT]) ctrl[CTRL_EN] <= 1'b0;

      if (wr_value) value <= merged[WIDTH-1:0];
      else if (term) begin
        if (!ctrl[CTRL_ONESHOT]) value <= '0;
      end else if (inc) value <= value + WIDTH'(1);

      if (wr_limit) limit <= merged[WIDTH-1:0];

      if (term) pending <= 1'b1;
      else if (clr_pending) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/user_proj_multi_counter.sv
// Multi-channel counter user project on the management Wishbone port.
// Owns bus decode, registered ack/read data, IRQ grouping and LA/GPIO mapping.
module user_proj_multi_counter
  import user_proj_mc_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          IO_PADS   = 38,
  parameter int          EVT_BASE  = 8
) (
`ifdef USE_POWER_PINS
  inout  wire                 vccd1,
  inout  wire                 vssd1,
`endif
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [127:0]        la_data_in,
  output logic [127:0]        la_data_out,
  input  logic [127:0]        la_oenb,
  input  logic [IO_PADS-1:0]  io_in,
  output logic [IO_PADS-1:0]  io_out,
  output logic [IO_PADS-1:0]  io_oeb,
  output logic [2:0]          irq
);

  localparam logic [4:0]  NCH_L   = 5'(NCH);
  localparam int unsigned LA_CH   = (NCH < 4) ? NCH : 4;
  localparam int unsigned GPIO_LO = EVT_BASE + NCH;

  logic                      hit, valid, accept, freeze;
  logic                      ack_q;
  logic [31:0]               dat_q, rdata;
  logic [3:0]                ch_idx;
  reg_sel_e                  reg_sel;
  logic [2:0]                irq_q, irq_next;
  logic [NCH-1:0]            ch_wr, ch_pending;
  logic [NCH-1:0][WIDTH-1:0] ch_value, ch_limit;
  logic [NCH-1:0][3:0]       ch_ctrl;
  logic                      unused_ok;

  assign hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign ch_idx  = wbs_adr_i[7:4];
  assign reg_sel = reg_sel_e'(wbs_adr_i[3:2]);
  assign valid   = (wbs_adr_i[11:8] == 4'd0) && ({1'b0, ch_idx} < NCH_L);
  // A cycle that just acked cannot accept, so a held strobe acks every other cycle.
  assign accept  = hit & ~ack_q;
  assign freeze  = ~la_oenb[FREEZE_LA_BIT] & la_data_in[FREEZE_LA_BIT];

  assign unused_ok = ^{wbs_adr_i[1:0], la_data_in[FREEZE_LA_BIT-1:0],
                       la_oenb[FREEZE_LA_BIT-1:0], io_in};

  // Per-channel write strobe for accepted, in-range writes.
  always_comb begin
    ch_wr = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      ch_wr[c] = accept & wbs_we_i & valid & (ch_idx == 4'(c));
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    mc_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .evt_pin (io_in[EVT_BASE+c]),
      .freeze  (freeze),
      .wr_en   (ch_wr[c]),
      .wr_reg  (reg_sel),
      .wr_data (wbs_dat_i),
      .wr_sel  (wbs_sel_i),
      .value   (ch_value[c]),
      .limit   (ch_limit[c]),
      .ctrl    (ch_ctrl[c]),
      .pending (ch_pending[c])
    );
  end

  // Read mux; out-of-range channels and offsets read as zero.
  always_comb begin
    rdata = '0;
    if (valid) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (ch_idx == 4'(c)) begin
          case (reg_sel)
            REG_CTRL:   rdata[3:0]       = ch_ctrl[c];
            REG_VALUE:  rdata[WIDTH-1:0] = ch_value[c];
            REG_LIMIT:  rdata[WIDTH-1:0] = ch_limit[c];
            REG_STATUS: begin
              rdata[STAT_PENDING] = ch_pending[c];
              rdata[STAT_RUNNING] = ch_ctrl[c][CTRL_EN];
            end
            default:    rdata = '0;
          endcase
        end
      end
    end
  end

  // Registered single-cycle ack with read data valid only alongside it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      dat_q <= accept ? rdata : '0;
    end
  end

  // Channels are grouped onto the three interrupt lines by index modulo 3.
  always_comb begin
    irq_next = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      irq_next[c % 3] = irq_next[c % 3] | (ch_pending[c] & ch_ctrl[c][CTRL_IRQ_EN]);
    end
  end

  // Interrupt output register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= '0;
    else          irq_q <= irq_next;
  end

  // First four channel values on the LA, 32 bits per channel.
  always_comb begin
    la_data_out = '0;
    for (int unsigned c = 0; c < LA_CH; c++) begin
      la_data_out[32*c +: WIDTH] = ch_value[c];
    end
  end

  // GPIO: event pins and the pads below them stay inputs; channel 0 drives the rest.
  always_comb begin
    io_out = '0;
    io_oeb = '0;
    for (int unsigned i = 0; i < IO_PADS; i++) begin
      if (i < GPIO_LO) begin
        io_oeb[i] = 1'b1;
      end else begin
        io_oeb[i] = wb_rst_i;
        if ((i - GPIO_LO) < WIDTH) io_out[i] = ch_value[0][i-GPIO_LO];
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;

endmodule
